imem_fetch_unit: RTL and testbench
==================================

Name: imem_fetch_unit

Overview:
- Parametrised, clocked instruction memory with a valid/ready fetch handshake, a byte loader port, a flush input and a fetch counter.
- Sits between the PC/fetch stage and IF/ID.
- Byte-addressed, big-endian word assembly: the lowest-addressed byte lands in the MSBs.
- Reads are registered with 1-cycle latency and sustain 1 fetch/cycle under backpressure.

Parameters:
ADDR_W, 32, width of fetch and loader addresses
DEPTH_BYTES, 1024, memory size in bytes; must be a power of two and at least WORD_BYTES
WORD_BYTES, 4, bytes per instruction; instruction width IW = 8*WORD_BYTES
CNT_W, 32, width of fetch counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  fetch request valid
req_ready  out  1  unit can accept a request this cycle
req_addr  in  ADDR_W  byte address of instruction
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts response
rsp_instr  out  IW  fetched instruction
rsp_addr  out  ADDR_W  address that produced rsp_instr
rsp_fault  out  1  alignment/range fault (see Optional Feature)
flush  in  1  discard pending and incoming fetches
ld_en  in  1  loader byte write strobe
ld_addr  in  ADDR_W  loader byte address
ld_data  in  8  loader byte
fetch_count  out  CNT_W  completed response handshakes, saturating

Behaviour:
- Storage: DEPTH_BYTES x 8 array, not cleared by reset; contents survive reset.
- Index: idx = addr[log2(DEPTH_BYTES)-1:0]. Byte k of a word comes from (idx+k) mod DEPTH_BYTES, so reads wrap at the top of memory.
- req_ready = !flush && (!rsp_valid || rsp_ready). This is combinational and gives zero-bubble streaming.
- Accept: req_valid && req_ready at edge N. At N+1: rsp_valid=1, rsp_instr = {mem[idx], mem[idx+1], ..., mem[idx+WORD_BYTES-1]}, rsp_addr=req_addr. Latency is exactly 1 cycle.
- Hold: while rsp_valid && !rsp_ready, rsp_instr, rsp_addr and rsp_fault stay stable. A later loader write to those bytes does not change the held response.
- Retire: rsp_valid && rsp_ready with no new accept → rsp_valid=0 next cycle. Retire and accept in the same cycle → the new response replaces the old one.
- Flush: rsp_valid=0 next cycle and any request presented that cycle is dropped (req_ready=0). Flush outranks a response handshake for the valid bit, but a handshake in the flush cycle still counts.
- Loader: ld_en at an edge writes ld_data to mem[ld_addr idx]. The loader operates independently of fetch.
  - A same-cycle read and write to the same byte returns the old byte (read-before-write).
- fetch_count increments by 1 on each rsp_valid && rsp_ready and saturates at 2^CNT_W-1.
- Reset (at any time, including mid-stream or while stalled):
  - rsp_valid=0, rsp_instr=0, rsp_addr=0, rsp_fault=0, fetch_count=0.
  - A pending response is dropped.
  - Reset outranks flush, accept and counting; loader writes in the reset cycle are still performed.
- Outputs are registered except req_ready.

Optional Feature:
IMEM_FAULT_EN
- Defined: an accepted request sets rsp_fault=1 and forces rsp_instr=0 if either:
  - req_addr mod WORD_BYTES != 0; or
  - req_addr > DEPTH_BYTES-WORD_BYTES, compared on the full ADDR_W value, with no wrap.
  - Otherwise rsp_fault=0. rsp_addr still reports the faulting address, and a fault still completes the handshake and counts.
- Undefined: rsp_fault is tied 0, no alignment check is made, and addresses wrap as above.

Test Plan:
- Load bytes 8C,96,00,01 at 0..3, then fetch addr 0 → next cycle rsp_valid=1, rsp_instr=32'h8C960001, rsp_addr=0; after handshake fetch_count=1.
- Back-to-back fetch of 0,4,8 with rsp_ready=1 → three consecutive valid cycles with the correct words. Then hold rsp_ready=0 for 3 cycles on the word at addr 4 → req_ready=0 and rsp_instr stable; release → no loss or duplication.
- Write the byte at addr 5 while the word at addr 4 is held → held value unchanged. Refetch addr 4 → new byte visible in bits 23:16.
- Flush asserted with rsp_valid=1 and req_valid=1 → rsp_valid=0 next cycle, request dropped, fetch_count unchanged unless rsp_ready was also 1.
- Reset while stalled with a valid response → all outputs 0 next cycle. Refetch addr 0 → the preloaded word is returned, proving contents are retained.
- IMEM_FAULT_EN: fetch addr 2 → rsp_fault=1, instr 0. Fetch addr 1021 → fault. Without the macro, addr 1022 → {mem[1022], mem[1023], mem[0], mem[1]} with rsp_fault=0.

Source files
------------

// File: rtl/imem_fetch_unit.sv
// -----------------------------------------------------------------------------
// imem_fetch_unit
// Byte-addressed instruction memory sitting between the PC/fetch stage and
// IF/ID. Fetches use a valid/ready handshake with a registered 1-cycle read
// and zero-bubble streaming; a byte loader port fills the memory.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   req_valid/req_ready   fetch request handshake (req_ready is combinational)
//   req_addr              byte address of the requested instruction
//   rsp_valid/rsp_ready   response handshake
//   rsp_instr/rsp_addr    fetched word (big-endian) and its address
//   rsp_fault             misalignment / out-of-range fault
//   flush                 drop the pending response and any request this cycle
//   ld_en/ld_addr/ld_data byte loader write port
//   fetch_count           saturating count of completed response handshakes
//
// Build option: define IMEM_FAULT_EN to enable alignment/range fault checks.
// Without it rsp_fault is tied low and every address wraps into the array.
// -----------------------------------------------------------------------------
module imem_fetch_unit #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_BYTES = 1024,
    parameter int WORD_BYTES  = 4,
    parameter int CNT_W       = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_W-1:0]       req_addr,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [8*WORD_BYTES-1:0] rsp_instr,
    output logic [ADDR_W-1:0]       rsp_addr,
    output logic                    rsp_fault,
    input  logic                    flush,
    input  logic                    ld_en,
    input  logic [ADDR_W-1:0]       ld_addr,
    input  logic [7:0]              ld_data,
    output logic [CNT_W-1:0]        fetch_count
);

    localparam int IW    = 8 * WORD_BYTES;
    localparam int IDX_W = $clog2(DEPTH_BYTES);

    // Storage has no reset: program contents must survive a core reset.
    logic [7:0]        mem_q [DEPTH_BYTES];

    logic              rsp_valid_q, rsp_valid_d;
    logic [IW-1:0]     rsp_instr_q, rsp_instr_d;
    logic [ADDR_W-1:0] rsp_addr_q,  rsp_addr_d;
    logic              rsp_fault_q, rsp_fault_d;
    logic [CNT_W-1:0]  fetch_count_q, fetch_count_d;

    logic              req_ready_s;
    logic              accept_s;
    logic              handshake_s;
    logic              fault_s;
    logic [IDX_W-1:0]  req_idx_s;
    logic [IW-1:0]     rd_word_s;
    logic              unused_s;

    // Address bits above the array index only matter to the fault check.
    assign unused_s = ^{req_addr[ADDR_W-1:IDX_W], ld_addr[ADDR_W-1:IDX_W]};

    assign req_idx_s   = req_addr[IDX_W-1:0];
    // A slot frees up when nothing is held or the held response retires now.
    assign req_ready_s = !flush && (!rsp_valid_q || rsp_ready);
    assign accept_s    = req_valid && req_ready_s;
    assign handshake_s = rsp_valid_q && rsp_ready;

    // Big-endian word assembly; the IDX_W-bit index wraps at the top of memory.
    // Reading the array before the edge gives read-before-write for the loader.
    always_comb begin
        rd_word_s = '0;
        for (int k = 0; k < WORD_BYTES; k++) begin
            rd_word_s[IW-1-8*k -: 8] = mem_q[req_idx_s + IDX_W'(k)];
        end
    end

`ifdef IMEM_FAULT_EN
    // Fault on misalignment or on a word that would run past the array end.
    always_comb begin
        fault_s = ((req_addr % ADDR_W'(WORD_BYTES)) != {ADDR_W{1'b0}}) ||
                  (req_addr > ADDR_W'(DEPTH_BYTES - WORD_BYTES));
    end
`else
    // No fault checking in this build.
    always_comb begin
        fault_s = 1'b0;
    end
`endif

    // Next-state for the response slot and the handshake counter.
    always_comb begin
        rsp_valid_d   = rsp_valid_q;
        rsp_instr_d   = rsp_instr_q;
        rsp_addr_d    = rsp_addr_q;
        rsp_fault_d   = rsp_fault_q;
        fetch_count_d = fetch_count_q;

        // Flush clears the valid bit, but a handshake in that cycle still counts.
        if (handshake_s && (fetch_count_q != {CNT_W{1'b1}})) begin
            fetch_count_d = fetch_count_q + CNT_W'(1);
        end else begin
            fetch_count_d = fetch_count_q;
        end

        // accept_s already implies no flush.
        if (flush) begin
            rsp_valid_d = 1'b0;
        end else if (accept_s) begin
            rsp_valid_d = 1'b1;
            rsp_instr_d = fault_s ? {IW{1'b0}} : rd_word_s;
            rsp_addr_d  = req_addr;
            rsp_fault_d = fault_s;
        end else if (handshake_s) begin
            rsp_valid_d = 1'b0;
        end else begin
            rsp_valid_d = rsp_valid_q;
        end
    end

    // Response and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q   <= 1'b0;
            rsp_instr_q   <= {IW{1'b0}};
            rsp_addr_q    <= {ADDR_W{1'b0}};
            rsp_fault_q   <= 1'b0;
            fetch_count_q <= {CNT_W{1'b0}};
        end else begin
            rsp_valid_q   <= rsp_valid_d;
            rsp_instr_q   <= rsp_instr_d;
            rsp_addr_q    <= rsp_addr_d;
            rsp_fault_q   <= rsp_fault_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Loader write port; deliberately independent of reset.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem_q[ld_addr[IDX_W-1:0]] <= ld_data;
        end
    end

    assign req_ready   = req_ready_s;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_instr   = rsp_instr_q;
    assign rsp_addr    = rsp_addr_q;
    assign rsp_fault   = rsp_fault_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_imem_fetch_unit.sv
module tb_imem_fetch_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_addr;
    logic        rsp_fault;
    logic        flush;
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [7:0]  ld_data;
    logic [31:0] fetch_count;

    int checks;
    int failures;

    // Reference model state
    logic [7:0]  m_mem [1024];
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_addr;
    logic        m_fault;
    logic [31:0] m_count;
    logic        rdy_seen;
    logic        rdy_exp;

    imem_fetch_unit dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
        .rsp_addr(rsp_addr), .rsp_fault(rsp_fault), .flush(flush),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .fetch_count(fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_word(input logic [31:0] a);
        logic [31:0] w;
        w = 32'd0;
        for (int k = 0; k < 4; k++) begin
            w = {w[23:0], m_mem[(a + 32'(k)) % 32'd1024]};
        end
        return w;
    endfunction

    function automatic logic model_fault(input logic [31:0] a);
`ifdef IMEM_FAULT_EN
        return ((a % 32'd4) != 32'd0) || (a > 32'd1020);
`else
        return 1'b0;
`endif
    endfunction

    // Apply the specification's rules for one rising edge.
    task automatic model_step();
        logic hs;
        logic rdy;
        hs  = m_valid && rsp_ready;
        rdy = !flush && (!m_valid || rsp_ready);
        if (reset) begin
            m_valid = 1'b0; m_instr = 32'd0; m_addr = 32'd0;
            m_fault = 1'b0; m_count = 32'd0;
        end else begin
            if (hs && m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
            if (flush) begin
                m_valid = 1'b0;
            end else if (req_valid && rdy) begin
                m_valid = 1'b1;
                m_fault = model_fault(req_addr);
                m_instr = m_fault ? 32'd0 : model_word(req_addr);
                m_addr  = req_addr;
            end else if (hs) begin
                m_valid = 1'b0;
            end
        end
        if (ld_en) m_mem[ld_addr % 32'd1024] = ld_data;
    endtask

    // Drive one cycle of inputs, sample req_ready, advance model, settle.
    task automatic cyc(input logic i_rst, input logic i_rv, input logic [31:0] i_ra,
                       input logic i_rr, input logic i_fl, input logic i_le,
                       input logic [31:0] i_la, input logic [7:0] i_ld);
        @(negedge clk);
        reset = i_rst; req_valid = i_rv; req_addr = i_ra; rsp_ready = i_rr;
        flush = i_fl; ld_en = i_le; ld_addr = i_la; ld_data = i_ld;
        #1;
        rdy_seen = req_ready;
        rdy_exp  = !i_fl && (!m_valid || i_rr);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0);
        checks++;
        if (rsp_valid !== 1'b0 || rsp_instr !== 32'd0 || rsp_addr !== 32'd0 ||
            rsp_fault !== 1'b0 || fetch_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs: got v=%b i=%h a=%h f=%b c=%0d want all zero",
                     rsp_valid, rsp_instr, rsp_addr, rsp_fault, fetch_count);
        end
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0);
        checks++;
        if (rdy_seen !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %b want 1", rdy_seen);
        end
    endtask

    task automatic test_load();
        logic [7:0] b;
        for (int i = 0; i < 1024; i++) begin
            case (i)
                0: b = 8'h8C;
                1: b = 8'h96;
                2: b = 8'h00;
                3: b = 8'h01;
                default: b = 8'($urandom());
            endcase
            cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'(i), b);
        end
        checks++;
        if (rsp_valid !== 1'b0 || fetch_count !== 32'd0) begin
            failures++;
            $display("FAIL load_idle: got v=%b c=%0d want v=0 c=0", rsp_valid, fetch_count);
        end
    endtask

    task automatic test_basic_fetch();
        cyc(1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_instr !== 32'h8C960001 || rsp_addr !== 32'd0 ||
            rsp_fault !== 1'b0) begin
            failures++;
            $display("FAIL basic_fetch: got v=%b i=%h a=%h f=%b want 1 8c960001 0 0",
                     rsp_valid, rsp_instr, rsp_addr, rsp_fault);
        end
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 8'd0);
        checks++;
        if (rsp_valid !== 1'b0 || fetch_count !== 32'd1) begin
            failures++;
            $display("FAIL basic_retire: got v=%b c=%0d want 0 1", rsp_valid, fetch_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w4;
        w4 = model_word(32'd4);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 32'(4 * i), 1'b1, 1'b0, 1'b0, 32'd0, 8'd0);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_instr !== model_word(32'(4 * i)) ||
                rsp_addr !== 32'(4 * i)) begin
                failures++;
                $display("FAIL b2b_word%0d: got v=%b i=%h a=%h want 1 %h %h", i,
                         rsp_valid, rsp_instr, rsp_addr, model_word(32'(4 * i)), 4 * i);
            end
        end
        cyc(1'b0, 1'b1, 32'd4, 1'b1, 1'b0, 1'b0, 32'd0, 8'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 32'd8, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0);
            checks++;
            if (rdy_seen !== 1'b0 || rsp_valid !== 1'b1 || rsp_instr !== w4 ||
                rsp_addr !== 32'd4) begin
                failures++;
                $display("FAIL stall_hold%0d: got r=%b v=%b i=%h a=%h want 0 1 %h 4", i,
                         rdy_seen, rsp_valid, rsp_instr, rsp_addr, w4);
            end
        end
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 8'd0);
        checks++;
        if (rsp_valid !== 1'b0 || fetch_count !== 32'd5) begin
            failures++;
            $display("FAIL stall_release: got v=%b c=%0d want 0 5", rsp_valid, fetch_count);
        end
    endtask

    task automatic test_hold_write();
        logic [31:0] w4_old;
        logic [7:0]  nb;
        w4_old = model_word(32'd4);
        nb     = ~m_mem[5];
        cyc(1'b0, 1'b1, 32'd4, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0);
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'd5, nb);
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0);
        checks++;
        if (rsp_instr !== w4_old || rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL held_after_write: got v=%b i=%h want 1 %h", rsp_valid, rsp_instr, w4_old);
        end
        cyc(1'b0, 1'b1, 32'd4, 1'b1, 1'b0, 1'b0, 32'd0, 8'd0);
        checks++;
        if (rsp_instr[23:16] !== nb || rsp_instr[31:24] !== w4_old[31:24] ||
            rsp_instr[15:0] !== w4_old[15:0]) begin
            failures++;
            $display("FAIL refetch_new_byte: got %h want byte1=%h", rsp_instr, nb);
        end
        checks++;
        if (fetch_count !== 32'd6) begin
            failures++;
            $display("FAIL hold_write_count: got %0d want 6", fetch_count);
        end
    endtask

    task automatic test_flush();
        cyc(1'b0, 1'b1, 32'd8, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0);
        cyc(1'b0, 1'b1, 32'd12, 1'b0, 1'b1, 1'b0, 32'd0, 8'd0);
        checks++;
        if (rdy_seen !== 1'b0 || rsp_valid !== 1'b0 || fetch_count !== 32'd6) begin
            failures++;
            $display("FAIL flush_no_hs: got r=%b v=%b c=%0d want 0 0 6",
                     rdy_seen, rsp_valid, fetch_count);
        end
        cyc(1'b0, 1'b1, 32'd8, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0);
        cyc(1'b0, 1'b1, 32'd12, 1'b1, 1'b1, 1'b0, 32'd0, 8'd0);
        checks++;
        if (rsp_valid !== 1'b0 || fetch_count !== 32'd7) begin
            failures++;
            $display("FAIL flush_with_hs: got v=%b c=%0d want 0 7", rsp_valid, fetch_count);
        end
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 8'd0);
        checks++;
        if (rsp_valid !== 1'b0 || fetch_count !== 32'd7) begin
            failures++;
            $display("FAIL flush_dropped: got v=%b c=%0d want 0 7", rsp_valid, fetch_count);
        end
    endtask

    task automatic test_reset_stall();
        logic [7:0] rb;
        rb = ~m_mem[100];
        cyc(1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0);
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0);
        cyc(1'b1, 1'b1, 32'd4, 1'b0, 1'b1, 1'b1, 32'd100, rb);
        checks++;
        if (rsp_valid !== 1'b0 || rsp_instr !== 32'd0 || rsp_addr !== 32'd0 ||
            rsp_fault !== 1'b0 || fetch_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_stalled: got v=%b i=%h a=%h f=%b c=%0d want all zero",
                     rsp_valid, rsp_instr, rsp_addr, rsp_fault, fetch_count);
        end
        cyc(1'b0, 1'b1, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 8'd0);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_instr !== 32'h8C960001) begin
            failures++;
            $display("FAIL retained_word: got v=%b i=%h want 1 8c960001", rsp_valid, rsp_instr);
        end
        cyc(1'b0, 1'b1, 32'd100, 1'b1, 1'b0, 1'b0, 32'd0, 8'd0);
        checks++;
        if (rsp_instr[31:24] !== rb || fetch_count !== 32'd1) begin
            failures++;
            $display("FAIL reset_cycle_load: got i=%h c=%0d want byte0=%h c=1",
                     rsp_instr, fetch_count, rb);
        end
    endtask

    task automatic test_edges();
        logic [31:0] wrap_w;
        logic [31:0] addrs [5];
        addrs[0] = 32'd1022; addrs[1] = 32'd2; addrs[2] = 32'd1021;
        addrs[3] = 32'd1020; addrs[4] = 32'h0000_1004;
        wrap_w = {m_mem[1022], m_mem[1023], m_mem[0], m_mem[1]};
        for (int i = 0; i < 5; i++) begin
            logic        ef;
            logic [31:0] ei;
`ifdef IMEM_FAULT_EN
            ef = (i != 3);
`else
            ef = 1'b0;
`endif
            ei = ef ? 32'd0 : (i == 0) ? wrap_w : model_word(addrs[i]);
            cyc(1'b0, 1'b1, addrs[i], 1'b1, 1'b0, 1'b0, 32'd0, 8'd0);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_fault !== ef || rsp_instr !== ei ||
                rsp_addr !== addrs[i]) begin
                failures++;
                $display("FAIL edge_%0h: got v=%b f=%b i=%h a=%h want 1 %b %h %h", addrs[i],
                         rsp_valid, rsp_fault, rsp_instr, rsp_addr, ef, ei, addrs[i]);
            end
        end
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 8'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return $urandom();
            1:       return 32'($urandom_range(0, 1023));
            default: return 32'(4 * $urandom_range(0, 255));
        endcase
    endfunction

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            cyc($urandom_range(0, 59) == 0, $urandom_range(0, 9) < 7, rand_addr(),
                $urandom_range(0, 9) < 6, $urandom_range(0, 11) == 0,
                $urandom_range(0, 9) < 3, rand_addr(), 8'($urandom()));
            checks++;
            if (rdy_seen !== rdy_exp) begin
                failures++;
                $display("FAIL rnd_ready@%0d: got %b want %b", n, rdy_seen, rdy_exp);
            end
            checks++;
            if (rsp_valid !== m_valid || rsp_fault !== m_fault) begin
                failures++;
                $display("FAIL rnd_valid_fault@%0d: got %b %b want %b %b", n,
                         rsp_valid, rsp_fault, m_valid, m_fault);
            end
            checks++;
            if (rsp_instr !== m_instr || rsp_addr !== m_addr) begin
                failures++;
                $display("FAIL rnd_data@%0d: got %h %h want %h %h", n,
                         rsp_instr, rsp_addr, m_instr, m_addr);
            end
            checks++;
            if (fetch_count !== m_count) begin
                failures++;
                $display("FAIL rnd_count@%0d: got %0d want %0d", n, fetch_count, m_count);
            end
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b0; req_valid = 1'b0; req_addr = 32'd0; rsp_ready = 1'b0;
        flush = 1'b0; ld_en = 1'b0; ld_addr = 32'd0; ld_data = 8'd0;
        m_valid = 1'b0; m_instr = 32'd0; m_addr = 32'd0; m_fault = 1'b0; m_count = 32'd0;
        rdy_seen = 1'b0; rdy_exp = 1'b0;
        test_reset();
        test_load();
        test_basic_fetch();
        test_back_to_back();
        test_hold_write();
        test_flush();
        test_reset_stall();
        test_edges();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
